// File: rtl/uart_tx_fifo_cfg.sv
// Parametrised UART transmitter with a small TX FIFO, run-time parity mode and
// stop-bit count, latched per frame; frames leave back-to-back while data is queued.
module uart_tx_fifo_cfg #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      par_mode,
  input  logic            stop2,
  output logic            full,
  output logic            empty,
  output logic            ovf_tick,
  output logic            busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int S_MAX = (2 * SB_TICK > OVS) ? 2 * SB_TICK : OVS;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] OVS_LAST = S_W'(OVS - 1);
  localparam logic [S_W-1:0] SB1_LAST = S_W'(SB_TICK - 1);
  localparam logic [S_W-1:0] SB2_LAST = S_W'(2 * SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST   = N_W'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DBIT-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;
  logic [DBIT-1:0]    head;
  logic               push;
  logic               pop;

  state_t             state;
  logic [S_W-1:0]     s;
  logic [N_W-1:0]     n;
  logic [DBIT-1:0]    shift;
  logic               par_bit;
  logic [1:0]         par_q;
  logic               stop2_q;
  logic [S_W-1:0]     stop_last;
  logic               stop_end;

  function automatic logic parity_of(input logic [DBIT-1:0] d, input logic [1:0] m);
    logic p;
    p = 1'b0;
    case (m)
      2'b01:   p = ^d;
      2'b10:   p = ~^d;
      2'b11:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  assign head  = mem[rptr];
  assign full  = (count == (FIFO_AW + 1)'(DEPTH));
  assign empty = (count == '0);
  // A pop in the same clk frees a slot, so a write to a full FIFO is still accepted then.
  assign push  = wr && (!full || pop);

  assign stop_last = stop2_q ? SB2_LAST : SB1_LAST;
  assign stop_end  = (state == STOP) && s_tick && (s == stop_last);
  assign pop       = !empty && ((state == IDLE) || stop_end);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ovf_tick <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + FIFO_AW'(1);
      if (pop)
        rptr <= rptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
      ovf_tick <= wr && full && !pop;
    end
  end

  // tx is loaded with the line level of the state being entered; a pop overrides the
  // case below so a new frame can start straight out of IDLE or the last stop tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      par_q        <= 2'b00;
      stop2_q      <= 1'b0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (s_tick) begin
            if (s == OVS_LAST) begin
              s     <= '0;
              n     <= '0;
              state <= DATA;
              tx    <= shift[0];
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == OVS_LAST) begin
              s     <= '0;
              shift <= shift >> 1;
              if (n == N_LAST) begin
                if (par_q != 2'b00) begin
                  state <= PARITY;
                  tx    <= par_bit;
                end else begin
                  state <= STOP;
                  tx    <= 1'b1;
                end
              end else begin
                n  <= n + N_W'(1);
                tx <= shift[1];
              end
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s == OVS_LAST) begin
              s     <= '0;
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == stop_last) begin
              s            <= '0;
              state        <= IDLE;
              tx           <= 1'b1;
              tx_done_tick <= 1'b1;
            end else begin
              s <= s + S_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
      if (pop) begin
        shift   <= head;
        par_q   <= par_mode;
        stop2_q <= stop2;
        par_bit <= parity_of(head, par_mode);
        s       <= '0;
        n       <= '0;
        state   <= START;
        tx      <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Parametrised UART transmitter that supersedes the fixed 8-bit, even-parity transmitter.
- Data width, oversampling ratio and FIFO depth are compile-time parameters.
- Parity mode and stop-bit count are run-time inputs, latched per frame.
- A small TX FIFO lets the host queue bytes; frames go out back-to-back.
- Sits between the bus/host write interface and the shared baud-tick generator that drives s_tick.

Parameters:
DBIT, 8, data bits per frame, legal range 5..9, sent LSB first
OVS, 16, s_tick pulses per start, data or parity bit
SB_TICK, 16, s_tick pulses per stop bit
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_tick  in  1  one-clk oversampling tick from baud generator
wr  in  1  push din into TX FIFO
din  in  DBIT  data word
par_mode  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit = 1)
stop2  in  1  0: one stop bit, 1: two stop bits
full  out  1  FIFO full
empty  out  1  FIFO empty
ovf_tick  out  1  one-clk pulse: write dropped because FIFO full
busy  out  1  FSM not in IDLE
tx_done_tick  out  1  one-clk pulse at end of each frame
tx  out  1  serial line, registered

Behaviour:
Reset values (asynchronous): tx=1, busy=0, tx_done_tick=0, ovf_tick=0, empty=1, full=0. FIFO pointers, counters and state are cleared. Reset mid-frame aborts the frame and tx returns to 1 immediately; queued data is lost.

FIFO:
- Synchronous, registered; full and empty are derived from the count.
- wr while full and no pop in the same clk: word is dropped and ovf_tick pulses in the next clk.
- wr and pop in the same clk while full: pop frees a slot and the write is accepted.
- wr and pop in the same clk while empty: no bypass; the word is written and is popped no earlier than the next clk.

FSM states:
- IDLE: tx=1. If !empty, pop the head word; latch data, par_mode and stop2 into shadow registers; compute the parity bit from the latched data; go to START.
- START: tx=0 for OVS ticks. On the OVS-th tick go to DATA with bit counter n=0 and tick counter s=0.
- DATA: tx=shift[0]. On the OVS-th tick shift right. After bit DBIT-1, go to PARITY if the latched par_mode≠00, else go to STOP.
- PARITY: tx=parity bit for OVS ticks, then go to STOP.
  - even: XOR of the data bits
  - odd: inverted XOR
  - mark: 1
- STOP: tx=1 for SB_TICK ticks, or 2*SB_TICK ticks if the latched stop2=1. At the last tick:
  - tx_done_tick is high in the following clk.
  - If the FIFO is not empty, pop and go directly to START (no idle bit, zero gap).
  - Otherwise go to IDLE.

Timing:
- tx is a register loaded with the line value of the next state. The START low level appears at the clk edge where the FSM leaves IDLE/STOP.
- With wr at edge k into an empty FIFO: empty=0 after k, pop and tx=0 at edge k+1.
- s counts s_tick pulses only. Bit durations are exact tick counts, independent of the clk/tick ratio.

Latching and widths:
- Changes on par_mode and stop2 mid-frame have no effect until the next pop.
- Counter widths: s holds up to 2*SB_TICK-1; n holds up to DBIT-1.
- busy = (state≠IDLE).

Test Plan:
1. DBIT=8, s_tick=1 constantly, par_mode=01, stop2=0, write 0x55. Required:
   - tx goes low 1 clk after wr.
   - Serial sequence 0,1,0,1,0,1,0,1,0,0(parity),1; each bit 16 clks; frame 176 clks.
   - One tx_done_tick.
2. par_mode=10, din=0x07 → parity bit 0. par_mode=00, same din → no parity bit, frame 160 clks. par_mode=11 → parity bit 1.
3. Six consecutive-clk writes A..F into an empty FIFO (depth 4). Required:
   - A is popped at once; B..E fill the FIFO; full=1.
   - F is dropped and ovf_tick pulses once.
   - Five frames A..E go out with no idle clocks between stop and next start; five tx_done_ticks; afterwards empty=1, busy=0.
4. stop2=1, then toggle stop2 to 0 mid-frame → the current frame's stop level lasts 32 ticks; the next frame uses 16.
5. Reset asserted in the middle of data bit 3 → tx=1, busy=0, empty=1 asynchronously, before the next clk edge; no tx_done_tick; a new write after reset release transmits a clean frame.
6. s_tick every 4th clk → each bit lasts 64 clks; a tick pulse coincident with wr is not counted toward START.
